// File: rtl/reglk_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : reglk_pkg
//  Description : Shared types, constants and helpers for the register-lock
//                bank: unlock FSM state type, index-width helper and the
//                width of the optional violation counter.
//  Revision    : 1.0 - initial release
// ============================================================================
package reglk_pkg;

    typedef enum logic [1:0] {
        LOCKED   = 2'd0,
        HOLD     = 2'd1,
        UNLOCKED = 2'd2
    } reglk_state_e;

    localparam int VIOL_CNT_W = 16;

    // Width of a word index; never below 1 so a single-word bank still has
    // a real index port.
    function automatic int idx_w(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage : reglk_pkg
`default_nettype wire

// File: rtl/reglk_unlock_fsm.sv
`default_nettype none
// ============================================================================
//  Module      : reglk_unlock_fsm
//  Description : Debug-unlock qualifier. jtag_unlock_i must stay high for
//                UNLOCK_HOLD counted cycles in HOLD before the bank unlocks;
//                dropping it at any point returns to LOCKED.
//  Ports       : clk_i          - clock, rising edge
//                rst_i          - synchronous active-high reset
//                jtag_unlock_i  - debug unlock request (level)
//                state_o        - current FSM state
//                unlock_pulse_o - high in the cycle whose closing edge
//                                 enters UNLOCKED
//  Revision    : 1.0 - initial release
// ============================================================================
module reglk_unlock_fsm
    import reglk_pkg::*;
#(
    parameter int UNLOCK_HOLD = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         jtag_unlock_i,
    output reglk_state_e state_o,
    output logic         unlock_pulse_o
);

    localparam logic [1:0] c_ST_LOCKED   = 2'd0;
    localparam logic [1:0] c_ST_HOLD     = 2'd1;
    localparam logic [1:0] c_ST_UNLOCKED = 2'd2;

    localparam int CNT_W = $clog2(UNLOCK_HOLD + 1);
    localparam logic [CNT_W-1:0] c_HOLD_CNT = CNT_W'(UNLOCK_HOLD);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             w_enter;

    // Combinational so the top can clear words on the very edge that enters
    // UNLOCKED, not one cycle later.
    assign w_enter = (r_state == c_ST_HOLD) && jtag_unlock_i && (r_cnt == c_HOLD_CNT);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_LOCKED;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                c_ST_LOCKED: begin
                    if (jtag_unlock_i) begin
                        r_state <= c_ST_HOLD;
                        r_cnt   <= CNT_W'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (!jtag_unlock_i) begin
                        r_state <= c_ST_LOCKED;
                        r_cnt   <= '0;
                    end else if (w_enter) begin
                        r_state <= c_ST_UNLOCKED;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                c_ST_UNLOCKED: begin
                    if (!jtag_unlock_i) begin
                        r_state <= c_ST_LOCKED;
                    end
                end
                default: begin
                    r_state <= c_ST_LOCKED;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    assign state_o        = reglk_state_e'(r_state);
    assign unlock_pulse_o = w_enter;

endmodule : reglk_unlock_fsm
`default_nettype wire

// File: rtl/reglk_bank_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : reglk_bank_ctrl
//  Description : Register-lock bank. Holds NUM_REGS lock words that gate
//                writes to protected registers. Words are set-only unless the
//                debug unlock FSM is UNLOCKED; a sticky lockdown flag rejects
//                all writes until reset or unlock.
//  Ports       : clk_i, rst_i             - clock, sync active-high reset
//                wr_en_i/idx/data         - single-cycle write request
//                wr_ack_o, wr_err_o       - completion/rejection, 1 cycle later
//                lockdown_i               - pulse, sets sticky lockdown
//                jtag_unlock_i            - debug unlock request (level)
//                unlocked_o               - FSM is UNLOCKED
//                reglk_o                  - registered lock words
//                viol_cnt_o, viol_idx_o   - audit outputs (REGLK_AUDIT_EN only)
//  Config      : define REGLK_AUDIT_EN to add the violation audit outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module reglk_bank_ctrl
    import reglk_pkg::*;
#(
    parameter int              NUM_REGS    = 6,
    parameter int              REG_W       = 32,
    parameter logic [REG_W-1:0] RST_VAL    = '1,
    parameter int              UNLOCK_HOLD = 16,
    localparam int             IDX_W       = idx_w(NUM_REGS)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           wr_en_i,
    input  logic [IDX_W-1:0]               wr_idx_i,
    input  logic [REG_W-1:0]               wr_data_i,
    output logic                           wr_ack_o,
    output logic                           wr_err_o,
    input  logic                           lockdown_i,
    input  logic                           jtag_unlock_i,
    output logic                           unlocked_o,
`ifdef REGLK_AUDIT_EN
    output logic [VIOL_CNT_W-1:0]          viol_cnt_o,
    output logic [IDX_W-1:0]               viol_idx_o,
`endif
    output logic [NUM_REGS-1:0][REG_W-1:0] reglk_o
);

    localparam logic [IDX_W:0] c_NUM_REGS = (IDX_W + 1)'(NUM_REGS);

    reglk_state_e                  w_state;
    logic                          w_unlock_pulse;
    logic                          w_unlocked;
    logic                          w_idx_bad;
    logic                          w_ld_active;
    logic                          w_wr_err;
    logic                          w_wr_ok;
    logic                          w_overwrite;

    logic [NUM_REGS-1:0][REG_W-1:0] r_words;
    logic                           r_lockdown;
    logic                           r_ack;
    logic                           r_err;

    reglk_unlock_fsm #(
        .UNLOCK_HOLD (UNLOCK_HOLD)
    ) u_unlock_fsm (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .jtag_unlock_i  (jtag_unlock_i),
        .state_o        (w_state),
        .unlock_pulse_o (w_unlock_pulse)
    );

    assign w_unlocked  = (w_state == UNLOCKED);
    assign w_idx_bad   = ({1'b0, wr_idx_i} >= c_NUM_REGS);
    // A lockdown pulse on the same edge as a write already blocks it.
    assign w_ld_active = r_lockdown | lockdown_i;
    // The unlock-entry edge clears lockdown, so a write there is not rejected
    // for lockdown (its data is still discarded by the clear).
    assign w_wr_err    = wr_en_i &&
                         (w_idx_bad || (w_ld_active && !w_unlocked && !w_unlock_pulse));
    assign w_wr_ok     = wr_en_i && !w_wr_err;
    // On the UNLOCKED->LOCKED edge (request dropped) writes are already set-only.
    assign w_overwrite = w_unlocked && jtag_unlock_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_words[i] <= RST_VAL;
            end
        end else if (w_unlock_pulse) begin
            r_words <= '0;
        end else if (w_wr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_idx_i == IDX_W'(i)) begin
                    r_words[i] <= w_overwrite ? wr_data_i : (r_words[i] | wr_data_i);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_lockdown <= 1'b0;
        end else if (w_unlock_pulse) begin
            r_lockdown <= 1'b0;
        end else if (lockdown_i && !w_unlocked) begin
            r_lockdown <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ack <= wr_en_i;
            r_err <= w_wr_err;
        end
    end

`ifdef REGLK_AUDIT_EN
    logic [VIOL_CNT_W-1:0] r_viol_cnt;
    logic [IDX_W-1:0]      r_viol_idx;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_viol_cnt <= '0;
            r_viol_idx <= '0;
        end else if (w_wr_err) begin
            if (r_viol_cnt != '1) begin
                r_viol_cnt <= r_viol_cnt + VIOL_CNT_W'(1);
            end
            r_viol_idx <= wr_idx_i;
        end
    end

    assign viol_cnt_o = r_viol_cnt;
    assign viol_idx_o = r_viol_idx;
`endif

    assign wr_ack_o   = r_ack;
    assign wr_err_o   = r_err;
    assign unlocked_o = w_unlocked;
    assign reglk_o    = r_words;

endmodule : reglk_bank_ctrl
`default_nettype wire
